// File: rtl/hbwif_sim_pkg.sv
// Shared types and constants for the HBWIF behavioural transceiver model.
package hbwif_sim_pkg;

  typedef enum logic {
    STARTUP = 1'b0,
    RUN     = 1'b1
  } state_e;

  localparam int DEF_DATA_WIDTH    = 10;
  localparam int DEF_SWING_WIDTH   = 4;
  localparam int DEF_ERR_CNT_WIDTH = 8;
  localparam int DEF_STARTUP_WORDS = 4;

  function automatic int cnt_width(input int data_width);
    return $clog2(data_width);
  endfunction

endpackage

// File: rtl/hbwif_sim_word_timer.sv
// Word timing for the transceiver model: bit counter with bitslip hold,
// slow clock, word strobe and startup word count.
module hbwif_sim_word_timer
  import hbwif_sim_pkg::*;
#(
  parameter int DATA_WIDTH    = DEF_DATA_WIDTH,
  parameter int STARTUP_WORDS = DEF_STARTUP_WORDS
) (
  input  logic clock,
  input  logic reset,
  input  logic i_run,
  input  logic i_bitslip,
  output logic o_boundary,
  output logic o_startup_done,
  output logic o_slow_clk,
  output logic o_word_strobe
);

  localparam int CW   = cnt_width(DATA_WIDTH);
  localparam int SW_W = (STARTUP_WORDS > 1) ? $clog2(STARTUP_WORDS) : 1;
  localparam logic [CW-1:0]   LAST    = CW'(DATA_WIDTH - 1);
  localparam logic [CW-1:0]   HALF    = CW'(DATA_WIDTH / 2);
  localparam logic [SW_W-1:0] SU_LAST = SW_W'(STARTUP_WORDS - 1);

  logic [CW-1:0]   r_cnt;
  logic [SW_W-1:0] r_su_cnt;
  logic            r_slip_pending;
  logic            r_slow;
  logic            r_strobe;
  logic            w_hold;

  // A slip freezes the counter for one cycle; the pending flag limits it to one per word.
  assign w_hold         = i_bitslip && i_run && !r_slip_pending;
  assign o_boundary     = (r_cnt == LAST) && !w_hold;
  assign o_startup_done = o_boundary && !i_run && (r_su_cnt == SU_LAST);
  assign o_slow_clk     = r_slow;
  assign o_word_strobe  = r_strobe;

  always_ff @(posedge clock) begin
    if (reset) begin
      r_cnt          <= '0;
      r_su_cnt       <= '0;
      r_slip_pending <= 1'b0;
      r_slow         <= 1'b0;
      r_strobe       <= 1'b0;
    end else begin
      if (!w_hold) begin
        r_cnt <= o_boundary ? '0 : r_cnt + 1'b1;
      end
      if (w_hold) begin
        r_slip_pending <= 1'b1;
      end else if (o_boundary) begin
        r_slip_pending <= 1'b0;
      end
      r_slow   <= (r_cnt < HALF);
      r_strobe <= o_boundary;
      if (o_boundary && !i_run) begin
        r_su_cnt <= r_su_cnt + 1'b1;
      end
    end
  end

endmodule

// File: rtl/hbwif_sim_transceiver.sv
// Behavioural serdes model on the bit clock: LSB-first serializer, bit-slip
// deserializer, electrical idle and diff-error count. Optional HBWIF_SIM_LOOPBACK_EN.
module hbwif_sim_transceiver
  import hbwif_sim_pkg::*;
#(
  parameter int DATA_WIDTH    = DEF_DATA_WIDTH,
  parameter int SWING_WIDTH   = DEF_SWING_WIDTH,
  parameter int ERR_CNT_WIDTH = DEF_ERR_CNT_WIDTH,
  parameter int STARTUP_WORDS = DEF_STARTUP_WORDS
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic                     rx_p,
  input  logic                     rx_n,
  output logic                     tx_p,
  output logic                     tx_n,
  input  logic [DATA_WIDTH-1:0]    data_tx,
  output logic [DATA_WIDTH-1:0]    data_rx,
  output logic                     slowClk,
  output logic                     word_strobe,
  output logic                     ready,
  input  logic                     bitslip,
  input  logic [SWING_WIDTH-1:0]   extraInputs_txSwing,
  input  logic                     extraInputs_cdrMode,
`ifdef HBWIF_SIM_LOOPBACK_EN
  input  logic                     loopback,
`endif
  output logic [ERR_CNT_WIDTH-1:0] diff_err_cnt
);

  state_e                   r_state;
  state_e                   w_state_next;
  logic [DATA_WIDTH-1:0]    r_tx_sh;
  logic                     r_tx_en;
  logic [DATA_WIDTH-1:0]    r_rx_sh;
  logic [DATA_WIDTH-1:0]    r_data_rx;
  logic [ERR_CNT_WIDTH-1:0] r_err;
  logic                     w_run;
  logic                     w_boundary;
  logic                     w_startup_done;
  logic                     w_rx_bit;
  logic                     w_diff_err;
  logic [DATA_WIDTH-1:0]    w_rx_next;

  hbwif_sim_word_timer #(
    .DATA_WIDTH   (DATA_WIDTH),
    .STARTUP_WORDS(STARTUP_WORDS)
  ) u_timer (
    .clock         (clock),
    .reset         (reset),
    .i_run         (w_run),
    .i_bitslip     (bitslip),
    .o_boundary    (w_boundary),
    .o_startup_done(w_startup_done),
    .o_slow_clk    (slowClk),
    .o_word_strobe (word_strobe)
  );

  always_ff @(posedge clock) begin
    if (reset) r_state <= STARTUP;
    else       r_state <= w_state_next;
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      STARTUP: if (w_startup_done) w_state_next = RUN;
      RUN:     w_state_next = RUN;
      default: w_state_next = STARTUP;
    endcase
  end

  assign w_run = (r_state == RUN);
  assign ready = w_run;

  // Loopback taps the ungated serial bit, so the round trip is independent of swing.
`ifdef HBWIF_SIM_LOOPBACK_EN
  assign w_rx_bit   = loopback ? r_tx_sh[0] : rx_p;
  assign w_diff_err = extraInputs_cdrMode && !loopback && (rx_p == rx_n);
`else
  assign w_rx_bit   = rx_p;
  assign w_diff_err = extraInputs_cdrMode && (rx_p == rx_n);
`endif

  assign w_rx_next    = {w_rx_bit, r_rx_sh[DATA_WIDTH-1:1]};
  assign tx_p         = r_tx_sh[0] & r_tx_en;
  assign tx_n         = ~r_tx_sh[0] & r_tx_en;
  assign data_rx      = r_data_rx;
  assign diff_err_cnt = r_err;

  always_ff @(posedge clock) begin
    if (reset) begin
      r_tx_sh   <= '0;
      r_tx_en   <= 1'b0;
      r_rx_sh   <= '0;
      r_data_rx <= '0;
      r_err     <= '0;
    end else begin
      if (w_boundary) r_tx_sh <= w_run ? data_tx : '0;
      else            r_tx_sh <= r_tx_sh >> 1;
      r_tx_en <= |extraInputs_txSwing;
      r_rx_sh <= w_rx_next;
      if (w_boundary && w_run) r_data_rx <= w_rx_next;
      if (w_diff_err && !(&r_err)) r_err <= r_err + 1'b1;
    end
  end

endmodule

// File: tb/tb_hbwif_sim_transceiver.sv
// Self-checking bench for hbwif_sim_transceiver against a word-level reference model.
`timescale 1ns/1ps
module tb_hbwif_sim_transceiver;

  localparam int DW  = 10;
  localparam int SWW = 4;
  localparam int EW  = 8;
  localparam int SW  = 4;

  logic           clock = 1'b0;
  logic           reset = 1'b1;
  logic           rx_p = 1'b0;
  logic           rx_n = 1'b1;
  logic           bitslip = 1'b0;
  logic           cdr = 1'b0;
  logic [DW-1:0]  data_tx = '0;
  logic [SWW-1:0] swing = 4'h8;
  logic           tx_p, tx_n, slowClk, word_strobe, ready;
  logic [DW-1:0]  data_rx;
  logic [EW-1:0]  diff_err_cnt;
`ifdef HBWIF_SIM_LOOPBACK_EN
  logic           loopback = 1'b0;
`endif

  int n_checks = 0;
  int n_err    = 0;

  always #5 clock = ~clock;

  hbwif_sim_transceiver dut (
    .clock              (clock),
    .reset              (reset),
    .rx_p               (rx_p),
    .rx_n               (rx_n),
    .tx_p               (tx_p),
    .tx_n               (tx_n),
    .data_tx            (data_tx),
    .data_rx            (data_rx),
    .slowClk            (slowClk),
    .word_strobe        (word_strobe),
    .ready              (ready),
    .bitslip            (bitslip),
    .extraInputs_txSwing(swing),
    .extraInputs_cdrMode(cdr),
`ifdef HBWIF_SIM_LOOPBACK_EN
    .loopback           (loopback),
`endif
    .diff_err_cnt       (diff_err_cnt)
  );

  // Reference model: absolute edge times of word boundaries, the word being
  // serialized, and the history of received bits.
  int            m_t, m_words, m_next_bd, m_tx_idx, m_err;
  bit            m_bd, m_slipped, m_any_slip, m_en, m_tx_bit;
  logic [DW-1:0] m_tx_word, m_data_rx;
  bit            q[$];

  bit            drive_stream = 0;
  int            off = 0;
  logic [DW-1:0] align_w = 10'h17C;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic model_edge();
    bit run_b, lb, smp;
    if (reset) begin
      m_t = 0; m_words = 0; m_next_bd = DW; m_tx_idx = 0; m_err = 0;
      m_bd = 0; m_slipped = 0; m_any_slip = 0; m_en = 0; m_tx_bit = 0;
      m_tx_word = '0; m_data_rx = '0;
      q.delete();
      repeat (DW) q.push_back(1'b0);
      return;
    end
    lb = 0;
`ifdef HBWIF_SIM_LOOPBACK_EN
    lb = loopback;
`endif
    run_b = (m_words >= SW);
    m_t++;
    if (bitslip && run_b && !m_slipped) begin
      m_next_bd++;
      m_slipped = 1; m_any_slip = 1;
    end
    m_bd = (m_t == m_next_bd);
    smp = lb ? m_tx_bit : rx_p;
    q.push_back(smp);
    void'(q.pop_front());
    if (cdr && !lb && (rx_p == rx_n) && m_err < 255) m_err++;
    if (m_bd) begin
      if (run_b) for (int k = 0; k < DW; k++) m_data_rx[k] = q[k];
      m_tx_word = run_b ? data_tx : '0;
      m_tx_idx  = 0;
      m_words++;
      m_next_bd = m_t + DW;
      m_slipped = 0;
    end else begin
      m_tx_idx++;
    end
    m_tx_bit = (m_tx_idx < DW) ? m_tx_word[m_tx_idx] : 1'b0;
    m_en     = (swing != 0);
  endtask

  task automatic step();
    @(posedge clock);
    #1;
    model_edge();
    chk("word_strobe", word_strobe, m_bd);
    chk("ready", ready, (m_words >= SW));
    chk("tx_p", tx_p, m_tx_bit & m_en);
    chk("tx_n", tx_n, ~m_tx_bit & m_en);
    chk("data_rx", data_rx, m_data_rx);
    chk("diff_err_cnt", diff_err_cnt, m_err);
    if (!m_any_slip)
      chk("slowClk", slowClk, ((m_t >= 1) && (((m_t - 1) % DW) < DW / 2)) ? 1 : 0);
  endtask

  task automatic tick();
    if (drive_stream) begin
      rx_p = align_w[(m_t + 1 + off) % DW];
      rx_n = ~rx_p;
    end
    step();
  endtask

  task automatic to_bd();
    int k;
    k = 0;
    do begin
      tick();
      k++;
    end while (!m_bd && k < 2 * DW + 2);
    chk("boundary_reached", word_strobe, 1);
  endtask

  task automatic cap_word(output logic [DW-1:0] w);
    for (int i = 0; i < DW; i++) begin
      w[i] = tx_p;
      step();
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [DW-1:0] cap, prev_w;
    int t_rise;

    // Reset state
    reset = 1'b1;
    repeat (3) step();
    reset = 1'b0;

    // Startup: ready at edge 40, strobe every 10, slowClk period 10
    t_rise = -1;
    for (int i = 0; i < 60; i++) begin
      data_tx = DW'($urandom);
      step();
      if (ready && t_rise < 0) t_rise = m_t;
    end
    chk("ready_rise_edge", t_rise, 40);

    // Serialize 2A5 LSB first
    data_tx = 10'h2A5;
    to_bd();
    cap_word(cap);
    chk("ser_2A5", cap, 10'h2A5);

    // Electrical idle mid-word, then restore
    data_tx = DW'($urandom);
    repeat (4) step();
    swing = 4'h0;
    step();
    chk("idle_tx_p", tx_p, 0);
    chk("idle_tx_n", tx_n, 0);
    repeat (7) step();
    swing = 4'h8;
    data_tx = 10'h1B3;
    to_bd();
    cap_word(cap);
    chk("ser_after_idle", cap, 10'h1B3);

    // Random traffic with slips, idle and diff errors
    cdr = 1'b1;
    for (int i = 0; i < 400; i++) begin
      data_tx = DW'($urandom);
      rx_p    = 1'($urandom);
      rx_n    = ($urandom % 6 == 0) ? rx_p : ~rx_p;
      if ($urandom % 40 == 0) cdr = ~cdr;
      swing   = ($urandom % 8 == 0) ? 4'h0 : 4'($urandom_range(1, 15));
      bitslip = ($urandom % 12 == 0);
      step();
    end
    bitslip = 1'b0;
    cdr     = 1'b0;
    swing   = 4'h8;

    // Word 17C offset by 3 bits, realigned with 3 slips
    off = ((16 - m_next_bd) % DW + DW) % DW;
    drive_stream = 1;
    repeat (2 * DW + 1) tick();
    chk("misaligned", (data_rx == 10'h17C) ? 1 : 0, 0);
    for (int s = 0; s < 3; s++) begin
      to_bd();
      repeat (3) tick();
      bitslip = 1'b1;
      tick();
      bitslip = 1'b0;
    end
    for (int i = 0; i < 3 * DW; i++) begin
      tick();
      if (m_bd) chk("aligned_17C", data_rx, 10'h17C);
    end

    // Slip coincident with the last bit, and a second slip in the same word
    while (m_t != m_next_bd - 1) tick();
    bitslip = 1'b1;
    tick();
    chk("slip_at_last_delays", word_strobe, 0);
    tick();
    chk("second_slip_ignored", word_strobe, 1);
    bitslip = 1'b0;
    drive_stream = 0;

    // Error counter saturation and hold
    reset = 1'b1;
    step();
    reset = 1'b0;
    cdr = 1'b1; rx_p = 1'b1; rx_n = 1'b1;
    repeat (300) step();
    chk("err_saturated", diff_err_cnt, 8'hFF);
    cdr = 1'b0;
    repeat (20) step();
    chk("err_hold", diff_err_cnt, 8'hFF);
    rx_n = 1'b0;

`ifdef HBWIF_SIM_LOOPBACK_EN
    // Loopback round trip of two word periods, independent of swing
    loopback = 1'b1;
    to_bd();
    prev_w = data_tx;
    for (int w = 0; w < 8; w++) begin
      data_tx = DW'($urandom);
      swing   = ($urandom % 3 == 0) ? 4'h0 : 4'h8;
      rx_p    = 1'($urandom);
      to_bd();
      chk("loopback_rt", data_rx, prev_w);
      prev_w = data_tx;
    end
    loopback = 1'b0;
    swing = 4'h8;
`endif

    // Reset mid-word
    data_tx = 10'h3FF;
    to_bd();
    data_tx = 10'h155;
    repeat (4) step();
    reset = 1'b1;
    step();
    chk("rst_tx_p", tx_p, 0);
    chk("rst_tx_n", tx_n, 0);
    chk("rst_slowClk", slowClk, 0);
    chk("rst_ready", ready, 0);
    chk("rst_data_rx", data_rx, 0);
    reset = 1'b0;
    repeat (15) step();

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
